// File: rtl/seq_det_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seq_det_pkg
//  Brief    : Shared constants and sizing helpers for the serial pattern
//             detector family.
//  Revision : 1.0  initial parametrised release
// ============================================================================
package seq_det_pkg;

    // Pattern used by the original fixed detector, MSB received first
    localparam logic [4:0] SEQ_10010 = 5'b10010;

    localparam int PAT_LEN_DEFAULT = 5;
    localparam int CNT_W_DEFAULT   = 8;

    // Bits needed to count 0..n inclusive
    function automatic int fill_width(input int n);
        return $clog2(n + 1);
    endfunction

    // Largest value a w-bit saturating counter can hold
    function automatic int cnt_max(input int w);
        return (1 << w) - 1;
    endfunction

    localparam int FILL_W  = fill_width(PAT_LEN_DEFAULT);
    localparam int CNT_MAX = cnt_max(CNT_W_DEFAULT);

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module   : sat_counter
//  Brief    : Up counter that sticks at its maximum value; clear has
//             priority over increment.
//  Revision : 1.0  initial release
// ============================================================================
module sat_counter
    import seq_det_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_count
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(cnt_max(CNT_W));

    logic [CNT_W-1:0] r_count;

    // Count increments, holding once the top value is reached
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != c_CNT_MAX)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/seq_detector_param.sv
`default_nettype none
// ============================================================================
//  Module   : seq_detector_param
//  Brief    : Serial bit-pattern detector with elaboration-time pattern,
//             run-time overlap selection, sample enable, synchronous clear
//             and a saturating match counter.
//  Revision : 1.0  initial parametrised release
// ============================================================================
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int                 PAT_LEN = PAT_LEN_DEFAULT,
    parameter logic [PAT_LEN-1:0] PATTERN = PAT_LEN'(SEQ_10010),
    parameter int                 CNT_W   = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             x,
    input  logic             overlap,
    input  logic             clear,
    output logic             z,
    output logic [CNT_W-1:0] match_cnt,
    output logic             busy
);

    localparam int                FILL_W_L = fill_width(PAT_LEN);
    localparam logic [FILL_W_L-1:0] c_FULL = FILL_W_L'(PAT_LEN);

    // Reject out-of-range sizing at elaboration
    if ((PAT_LEN < 2) || (PAT_LEN > 16)) begin : g_bad_pat_len
        $error("seq_detector_param: PAT_LEN must be 2..16");
    end
    if ((CNT_W < 1) || (CNT_W > 16)) begin : g_bad_cnt_w
        $error("seq_detector_param: CNT_W must be 1..16");
    end

    logic [PAT_LEN-1:0]  r_hist;
    logic [FILL_W_L-1:0] r_fill;
    logic                r_z;

    logic [FILL_W_L-1:0] w_fill_cur;
    logic [FILL_W_L-1:0] w_fill_n;
    logic [PAT_LEN-1:0]  w_hist_n;
    logic                w_match;

    // Next history/fill and match decision for a sampled bit. A fill value
    // beyond PAT_LEN cannot occur normally and is treated as empty.
    always_comb begin
        w_fill_cur = (r_fill > c_FULL) ? '0 : r_fill;
        w_fill_n   = (w_fill_cur == c_FULL) ? c_FULL : (w_fill_cur + 1'b1);
        w_hist_n   = {r_hist[PAT_LEN-2:0], x};
        w_match    = en && (w_fill_n == c_FULL) && (w_hist_n == PATTERN);
    end

    // History shift register, fill tracking and registered match pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hist <= '0;
            r_fill <= '0;
            r_z    <= 1'b0;
        end else if (clear) begin
            r_hist <= '0;
            r_fill <= '0;
            r_z    <= 1'b0;
        end else if (en) begin
            r_hist <= w_hist_n;
            r_z    <= w_match;
            // A non-overlapped match consumes its bits entirely
            r_fill <= (w_match && !overlap) ? '0 : w_fill_n;
        end else begin
            r_z    <= 1'b0;
            r_fill <= w_fill_cur;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (w_match),
        .i_clr   (clear),
        .o_count (match_cnt)
    );

    assign z    = r_z;
    assign busy = (r_fill != '0);

endmodule
`default_nettype wire

// File: tb/tb_seq_detector_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_detector_param
//  Brief    : Scoreboard bench for seq_detector_param; two instances (8-bit
//             and 2-bit counters) share one stimulus stream.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seq_detector_param;

    localparam int PL  = 5;
    localparam int PAT = 18;   // 5'b10010 as an integer, first bit = MSB

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       x = 1'b0;
    logic       overlap = 1'b1;
    logic       clear = 1'b0;
    logic       z_a, busy_a, z_b, busy_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic z;
        int   ca;
        int   cb;
        logic busy;
    } exp_t;

    exp_t q[$];
    exp_t m_e;

    // Reference model: the bits that may still form a match, newest last
    bit win[$];
    int mcnt_a = 0;
    int mcnt_b = 0;
    bit mz = 1'b0;

    always #5 clk = ~clk;

    seq_detector_param u_dut_a (
        .clk(clk), .reset(reset), .en(en), .x(x), .overlap(overlap),
        .clear(clear), .z(z_a), .match_cnt(cnt_a), .busy(busy_a)
    );

    seq_detector_param #(.CNT_W(2)) u_dut_b (
        .clk(clk), .reset(reset), .en(en), .x(x), .overlap(overlap),
        .clear(clear), .z(z_b), .match_cnt(cnt_b), .busy(busy_b)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int pack_win();
        int v = 0;
        foreach (win[i]) v = v * 2 + int'(win[i]);
        return v;
    endfunction

    // Apply one cycle of inputs and queue the outputs expected after the edge
    task automatic drive(input bit r, input bit e, input bit xi, input bit ov, input bit cl);
        exp_t ex;
        @(negedge clk);
        reset = r; en = e; x = xi; overlap = ov; clear = cl;
        if (r || cl) begin
            win.delete();
            mz = 1'b0;
            mcnt_a = 0;
            mcnt_b = 0;
        end else if (e) begin
            win.push_back(xi);
            if (win.size() > PL) void'(win.pop_front());
            mz = (win.size() == PL) && (pack_win() == PAT);
            if (mz) begin
                if (mcnt_a < 255) mcnt_a++;
                if (mcnt_b < 3) mcnt_b++;
                if (!ov) win.delete();
            end
        end else begin
            mz = 1'b0;
        end
        ex.z = mz; ex.ca = mcnt_a; ex.cb = mcnt_b; ex.busy = (win.size() != 0);
        q.push_back(ex);
        if (r) begin
            #1;
            chk("async_z", int'(z_a), 0);
            chk("async_cnt", int'(cnt_a), 0);
            chk("async_busy", int'(busy_a), 0);
        end
    endtask

    task automatic feed(input int bits, input int n, input bit ov);
        for (int i = n - 1; i >= 0; i--) drive(1'b0, 1'b1, bit'((bits >> i) & 1), ov, 1'b0);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: compare queued expectations just after each active edge
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            m_e = q.pop_front();
            chk("z_a", int'(z_a), int'(m_e.z));
            chk("cnt_a", int'(cnt_a), m_e.ca);
            chk("busy_a", int'(busy_a), int'(m_e.busy));
            chk("z_b", int'(z_b), int'(m_e.z));
            chk("cnt_b", int'(cnt_b), m_e.cb);
            chk("busy_b", int'(busy_b), int'(m_e.busy));
        end
    end

    initial begin
        int pi;
        bit ov;
        bit xi;
        #1;
        chk("reset_z", int'(z_a), 0);
        chk("reset_cnt", int'(cnt_a), 0);
        chk("reset_busy", int'(busy_a), 0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

        // 1: overlapping, 10010010 -> two matches
        feed(8'b10010010, 8, 1'b1);
        settle();
        chk("t1_cnt", int'(cnt_a), 2);

        // 2: same stream non-overlapping -> one match, 3 bits pending
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        feed(8'b10010010, 8, 1'b0);
        settle();
        chk("t2_cnt", int'(cnt_a), 1);
        chk("t2_busy", int'(busy_a), 1);

        // 3: enable gap in the middle of a pattern
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        feed(4'b1001, 4, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        settle();
        chk("t3_z", int'(z_a), 1);
        chk("t3_cnt", int'(cnt_a), 1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // 4: six back-to-back patterns saturate the 2-bit counter
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 6; k++) feed(5'b10010, 5, 1'b1);
        settle();
        chk("t4_cnt_a", int'(cnt_a), 6);
        chk("t4_cnt_b", int'(cnt_b), 3);

        // 5: reset mid-pattern loses the partial match
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        feed(4'b1001, 4, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

        // 6: clear on the completing edge wins
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        feed(4'b1001, 4, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        settle();
        chk("t6_z", int'(z_a), 0);
        chk("t6_busy", int'(busy_a), 0);

        // Random phase, biased toward pattern bits to create matches
        pi = 0;
        ov = 1'b1;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 19) == 0) ov = ~ov;
            if ($urandom_range(0, 1) == 1) begin
                xi = bit'((PAT >> (PL - 1 - pi)) & 1);
                pi = (pi + 1) % PL;
            end else begin
                xi = bit'($urandom_range(0, 1));
            end
            drive(bit'($urandom_range(0, 99) == 0),
                  bit'($urandom_range(0, 9) < 8),
                  xi, ov,
                  bit'($urandom_range(0, 39) == 0));
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        settle();
        chk("queue_drain", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
